chacha_block_ctrl: RTL and testbench
====================================

// Module: chacha_block_ctrl
// PURPOSE
//  Sequences four chacha_qr instances to produce one 512-bit ChaCha keystream block per request.
//  Holds the 16x32-bit working state, alternates column and diagonal rounds, then adds the input state.
//  Owns the 64-bit block counter. Sits between the chacha core's API registers and the keystream XOR.
// PARAMETERS
//  ROUNDS  20  number of half-double-rounds (one column or diagonal round each); legal values 8, 12, 20
// PORTS
//  clk             in   1    system clock, rising edge
//  reset_n         in   1    asynchronous, active-low reset
//  init            in   1    pulse: load key/iv, counter:=0, generate block 0
//  next            in   1    pulse: counter+=1, generate next block
//  key             in   256  key; 128-bit keys use key[255:128]
//  keylen          in   1    0 = 128-bit key, 1 = 256-bit key
//  iv              in   64   nonce
//  ready           out  1    high in IDLE; init/next accepted only when ready
//  data_out        out  512  keystream block, word 0 at [511:480]
//  data_out_valid  out  1    data_out holds a finished block
//  block_ctr       out  64   counter value used for the current/last block
// BEHAVIOUR
//  Reset: ready=1, data_out_valid=0, data_out=0, block_ctr=0, all state regs 0, FSM=IDLE.
//  FSM: IDLE -> ROUNDS (on accepted init/next) -> FINAL -> IDLE.
//  Accept edge:
//   - build input state: w0..3 = constants (sigma if keylen=1, tau if 0); w4..11 = key words;
//     w12..13 = counter (low, high); w14..15 = iv.
//   - 128-bit key: w8..11 = w4..11 copy of key[255:128].
//   - Bus words are taken MSB-first and byte-reversed to little-endian.
//   - Latch input state and working state; ready:=0, data_out_valid:=0; round_ctr:=0.
//  ROUNDS, one round per clock:
//   - round_ctr even: column QRs (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
//   - round_ctr odd: diagonal QRs (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
//   - After ROUNDS rounds, go to FINAL.
//  FINAL, 1 clock:
//   - data_out word i = byte-reverse(work_i + in_i mod 2^32).
//   - data_out_valid:=1, ready:=1, go to IDLE.
//  Latency: data_out_valid rises ROUNDS+1 clocks after the accept edge (21 for ROUNDS=20).
//   Throughput: one block per ROUNDS+2 clocks.
//  init and next in the same cycle: init wins. init/next while ready=0: ignored, no queuing.
//  data_out and data_out_valid hold until the next accepted request.
//  Counter: init sets 0; next increments before building state. Wraps 2^64-1 -> 0 silently.
//  key/iv/keylen are sampled only on an accepted init. next reuses the latched key/iv.
//  next before any init after reset: accepted, uses the all-zero latched key/iv.
//  reset_n low mid-block: immediate return to reset values; the partial block is discarded.
//  All adds are 32-bit, carry discarded. No combinational path from inputs to outputs.
// STRUCTURE
//  chacha_pkg:
//   - SIGMA 0x61707865,0x3320646e,0x79622d32,0x6b206574
//   - TAU   0x61707865,0x3120646e,0x79622d36,0x6b206574
//   - FSM state encodings; the byte-reverse function.
//  Sub-module: chacha_qr (existing, combinational), instantiated 4x.
//   - Operand muxing between column and diagonal is done in this block.
// TESTING
//  1. Zero key (keylen=1), zero iv, ROUNDS=20, init
//     -> after 21 clks, data_out[511:256] = 76b8e0ad a0f13d90 405d6ae5 5386bd28
//        bdd219b8 a08ded1a a836efcc 8b770dc7.
//  2. Same key/iv, ROUNDS=8 -> data_out[511:448] = 3e00ef2f 895f40d6.
//     ROUNDS=12 -> 9bf49a6a 0755f953.
//  3. init then next -> block_ctr=1; the block matches the software model with counter 1.
//  4. Assert next and init in the same cycle, and also while ready=0
//     -> init wins; a mid-block request is ignored and the output is unchanged.
//  5. Force block_ctr to 0xFFFF_FFFF_FFFF_FFFF, then next
//     -> block_ctr=0, the block matches the model with counter 0.
//  6. reset_n low at round 7 -> ready=1, data_out_valid=0 immediately.
//     A following init gives the correct block.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared types, constants and helpers for the ChaCha block controller and its quarter-round.
package chacha_pkg;

    typedef logic [31:0]       word_t;
    typedef logic [15:0][31:0] words_t;
    typedef logic [3:0][31:0]  const_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUNDS = 2'd1,
        ST_FINAL  = 2'd2
    } fsm_e;

    // Index 0 is the first constant word ("expa").
    localparam const_t SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    localparam const_t TAU   = {32'h6b206574, 32'h79622d36, 32'h3120646e, 32'h61707865};

    function automatic word_t bswap(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic word_t rotl(input word_t w, input int unsigned n);
        return (w << n) | (w >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// ChaCha quarter-round, purely combinational; all adds are mod 2^32.
module chacha_qr
    import chacha_pkg::*;
(
    input  word_t i_a,
    input  word_t i_b,
    input  word_t i_c,
    input  word_t i_d,
    output word_t o_a,
    output word_t o_b,
    output word_t o_c,
    output word_t o_d
);

    word_t w_a0, w_b0, w_c0, w_d0;
    word_t w_a1, w_b1, w_c1, w_d1;

    assign w_a0 = i_a + i_b;
    assign w_d0 = rotl(i_d ^ w_a0, 16);
    assign w_c0 = i_c + w_d0;
    assign w_b0 = rotl(i_b ^ w_c0, 12);
    assign w_a1 = w_a0 + w_b0;
    assign w_d1 = rotl(w_d0 ^ w_a1, 8);
    assign w_c1 = w_c0 + w_d1;
    assign w_b1 = rotl(w_b0 ^ w_c1, 7);

    assign o_a = w_a1;
    assign o_b = w_b1;
    assign o_c = w_c1;
    assign o_d = w_d1;

endmodule

// File: rtl/chacha_block_ctrl.sv
// Sequences four quarter-rounds over the 16-word working state to produce one
// 512-bit ChaCha keystream block per accepted init/next request.
module chacha_block_ctrl
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic [63:0]  iv,
    output logic         ready,
    output logic [511:0] data_out,
    output logic         data_out_valid,
    output logic [63:0]  block_ctr
);

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    fsm_e         r_state, w_state_next;
    logic [4:0]   r_round;
    words_t       r_in, r_work;
    logic [255:0] r_key;
    logic         r_keylen;
    logic [63:0]  r_iv, r_ctr;
    logic [511:0] r_data_out;
    logic         r_valid;

    logic         w_accept;
    logic [255:0] w_key_sel;
    logic         w_kl_sel;
    logic [63:0]  w_iv_sel, w_ctr_sel;
    words_t       w_in, w_work_next;
    logic [511:0] w_final;
    word_t        w_qa [4], w_qb [4], w_qc [4], w_qd [4];
    word_t        w_ra [4], w_rb [4], w_rc [4], w_rd [4];

    assign w_accept  = (r_state == ST_IDLE) && (init || next);
    assign w_key_sel = init ? key    : r_key;
    assign w_kl_sel  = init ? keylen : r_keylen;
    assign w_iv_sel  = init ? iv     : r_iv;
    assign w_ctr_sel = init ? 64'd0  : r_ctr + 64'd1;

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        w_in = '0;
        for (int j = 0; j < 4; j++) begin
            w_in[j]     = w_kl_sel ? SIGMA[j] : TAU[j];
            w_in[4 + j] = bswap(w_key_sel[255 - 32*j -: 32]);
            w_in[8 + j] = w_kl_sel ? bswap(w_key_sel[127 - 32*j -: 32])
                                   : bswap(w_key_sel[255 - 32*j -: 32]);
        end
        w_in[12] = w_ctr_sel[31:0];
        w_in[13] = w_ctr_sel[63:32];
        w_in[14] = bswap(w_iv_sel[63:32]);
        w_in[15] = bswap(w_iv_sel[31:0]);
    end

    // Even rounds use columns, odd rounds shift rows 1..3 left by 1..3 for diagonals.
    for (genvar k = 0; k < 4; k++) begin : g_qr
        assign w_qa[k] = r_work[k];
        assign w_qb[k] = r_round[0] ? r_work[4 + ((k + 1) % 4)]  : r_work[4 + k];
        assign w_qc[k] = r_round[0] ? r_work[8 + ((k + 2) % 4)]  : r_work[8 + k];
        assign w_qd[k] = r_round[0] ? r_work[12 + ((k + 3) % 4)] : r_work[12 + k];

        chacha_qr u_qr (
            .i_a (w_qa[k]), .i_b (w_qb[k]), .i_c (w_qc[k]), .i_d (w_qd[k]),
            .o_a (w_ra[k]), .o_b (w_rb[k]), .o_c (w_rc[k]), .o_d (w_rd[k])
        );
    end

    always_comb begin
        w_work_next = r_work;
        for (int k = 0; k < 4; k++) begin
            w_work_next[k] = w_ra[k];
            if (r_round[0]) begin
                w_work_next[4 + ((k + 1) % 4)]  = w_rb[k];
                w_work_next[8 + ((k + 2) % 4)]  = w_rc[k];
                w_work_next[12 + ((k + 3) % 4)] = w_rd[k];
            end else begin
                w_work_next[4 + k]  = w_rb[k];
                w_work_next[8 + k]  = w_rc[k];
                w_work_next[12 + k] = w_rd[k];
            end
        end
    end

    always_comb begin
        w_final = '0;
        for (int i = 0; i < 16; i++) begin
            w_final[511 - 32*i -: 32] = bswap(r_work[i] + r_in[i]);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_next = ST_ROUNDS;
            ST_ROUNDS: if (r_round == LAST_ROUND) w_state_next = ST_FINAL;
            ST_FINAL:  w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the wide state and key registers are reset too, so a reset fully wipes key material.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_round    <= '0;
            r_in       <= '0;
            r_work     <= '0;
            r_key      <= '0;
            r_keylen   <= 1'b0;
            r_iv       <= '0;
            r_ctr      <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
        end else if (w_accept) begin
            r_in    <= w_in;
            r_work  <= w_in;
            r_round <= '0;
            r_valid <= 1'b0;
            r_ctr   <= w_ctr_sel;
            if (init) begin
                r_key    <= key;
                r_keylen <= keylen;
                r_iv     <= iv;
            end
        end else if (r_state == ST_ROUNDS) begin
            r_work  <= w_work_next;
            r_round <= r_round + 5'd1;
        end else if (r_state == ST_FINAL) begin
            r_data_out <= w_final;
            r_valid    <= 1'b1;
        end
    end

    assign ready          = (r_state == ST_IDLE);
    assign data_out       = r_data_out;
    assign data_out_valid = r_valid;
    assign block_ctr      = r_ctr;

endmodule

// File: tb/tb_chacha_block_ctrl.sv
// Self-checking bench: a software ChaCha model plus a per-cycle request/latency model.
module tb_chacha_block_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         init = 1'b0, next = 1'b0, aux_init = 1'b0;
    logic [255:0] key = '0;
    logic         keylen = 1'b1;
    logic [63:0]  iv = '0;

    logic         ready, data_out_valid;
    logic [511:0] data_out;
    logic [63:0]  block_ctr;
    logic         r8_ready, r8_valid, r12_ready, r12_valid;
    logic [511:0] r8_data, r12_data;
    logic [63:0]  r8_ctr, r12_ctr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chacha_block_ctrl #(.ROUNDS(20)) dut (
        .clk(clk), .reset_n(reset_n), .init(init), .next(next), .key(key), .keylen(keylen),
        .iv(iv), .ready(ready), .data_out(data_out), .data_out_valid(data_out_valid),
        .block_ctr(block_ctr)
    );
    chacha_block_ctrl #(.ROUNDS(8)) u_r8 (
        .clk(clk), .reset_n(reset_n), .init(aux_init), .next(1'b0), .key(key), .keylen(keylen),
        .iv(iv), .ready(r8_ready), .data_out(r8_data), .data_out_valid(r8_valid),
        .block_ctr(r8_ctr)
    );
    chacha_block_ctrl #(.ROUNDS(12)) u_r12 (
        .clk(clk), .reset_n(reset_n), .init(aux_init), .next(1'b0), .key(key), .keylen(keylen),
        .iv(iv), .ready(r12_ready), .data_out(r12_data), .data_out_valid(r12_valid),
        .block_ctr(r12_ctr)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- software reference ----------------
    function automatic logic [31:0] le(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] rl(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic kl,
                                               input logic [63:0] n, input logic [63:0] c,
                                               input int rounds);
        logic [31:0] s [16];
        logic [31:0] x [16];
        logic [511:0] r;
        int idx [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                           '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        s[0] = 32'h61707865;
        s[1] = kl ? 32'h3320646e : 32'h3120646e;
        s[2] = kl ? 32'h79622d32 : 32'h79622d36;
        s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) begin
            if (kl || i < 4) s[4+i] = le(k[255 - 32*i -: 32]);
            else             s[4+i] = le(k[255 - 32*(i-4) -: 32]);
        end
        s[12] = c[31:0];
        s[13] = c[63:32];
        s[14] = le(n[63:32]);
        s[15] = le(n[31:0]);
        x = s;
        for (int rd = 0; rd < rounds; rd++) begin
            for (int q = 0; q < 4; q++) begin
                int a, b, cc, d;
                a = idx[(rd % 2)*4 + q][0]; b = idx[(rd % 2)*4 + q][1];
                cc = idx[(rd % 2)*4 + q][2]; d = idx[(rd % 2)*4 + q][3];
                x[a] = x[a] + x[b];  x[d] = rl(x[d] ^ x[a], 16);
                x[cc] = x[cc] + x[d]; x[b] = rl(x[b] ^ x[cc], 12);
                x[a] = x[a] + x[b];  x[d] = rl(x[d] ^ x[a], 8);
                x[cc] = x[cc] + x[d]; x[b] = rl(x[b] ^ x[cc], 7);
            end
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = le(x[i] + s[i]);
        return r;
    endfunction

    // ---------------- cycle model of the request protocol ----------------
    int           m_busy = 0;
    logic         m_valid = 1'b0, m_fresh = 1'b1, m_keylen = 1'b0;
    logic [63:0]  m_ctr = '0, m_iv = '0;
    logic [255:0] m_key = '0;
    logic [511:0] m_data = '0, m_pend = '0;
    logic         run_cmp = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_valid = 1'b0; m_fresh = 1'b1; m_ctr = '0;
            m_key = '0; m_keylen = 1'b0; m_iv = '0; m_data = '0; m_pend = '0;
        end else if (m_busy == 0) begin
            if (init || next) begin
                if (init) begin
                    m_key = key; m_keylen = keylen; m_iv = iv; m_ctr = '0;
                end else begin
                    m_ctr = m_ctr + 64'd1;
                end
                m_pend  = ref_block(m_key, m_keylen, m_iv, m_ctr, 20);
                m_busy  = 21;
                m_valid = 1'b0;
                m_fresh = 1'b0;
            end
        end else begin
            m_busy--;
            if (m_busy == 0) begin
                m_valid = 1'b1;
                m_data  = m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("ready", {511'd0, ready}, {511'd0, m_busy == 0});
            check("valid", {511'd0, data_out_valid}, {511'd0, m_valid});
            check("block_ctr", {448'd0, block_ctr}, {448'd0, m_ctr});
            if (m_valid || m_fresh) check("data_out", data_out, m_data);
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("idle_timeout", 512'd0, 512'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!data_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!data_out_valid) check("valid_timeout", 512'd0, 512'd1);
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [511:0] t;
        logic [255:0] key_a, key_b, key_c;
        int lat;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        run_cmp = 1'b1;
        check("rst_ready", {511'd0, ready}, 512'd1);
        check("rst_valid", {511'd0, data_out_valid}, 512'd0);
        check("rst_data", data_out, 512'd0);
        check("rst_ctr", {448'd0, block_ctr}, 512'd0);
        reset_n = 1'b1;

        // Model pins against published vectors.
        t = ref_block('0, 1'b1, '0, '0, 20);
        check("model_r20", {256'd0, t[511:256]},
              {256'd0, 256'h76b8e0ad_a0f13d90_405d6ae5_5386bd28_bdd219b8_a08ded1a_a836efcc_8b770dc7});
        t = ref_block('0, 1'b1, '0, '0, 8);
        check("model_r8", {448'd0, t[511:448]}, {448'd0, 64'h3e00ef2f_895f40d6});

        // next before any init: zero latched key, 128-bit mode, counter 1.
        @(negedge clk);
        keylen = 1'b1; key = rand_key(); next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        wait_valid();
        check("next_first_ctr", {448'd0, block_ctr}, 512'd1);
        check("next_first_data", data_out, ref_block('0, 1'b0, '0, 64'd1, 20));

        // Zero key, 256-bit, with latency measurement and the 8/12-round siblings.
        wait_idle();
        key = '0; keylen = 1'b1; iv = '0; init = 1'b1; aux_init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0; aux_init = 1'b0;
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1 lat++;
            if (data_out_valid) break;
        end
        check("latency", 512'(lat), 512'd21);
        check("vec_r20", {256'd0, data_out[511:256]},
              {256'd0, 256'h76b8e0ad_a0f13d90_405d6ae5_5386bd28_bdd219b8_a08ded1a_a836efcc_8b770dc7});
        check("vec_r8_valid", {511'd0, r8_valid}, 512'd1);
        check("vec_r8", {448'd0, r8_data[511:448]}, {448'd0, 64'h3e00ef2f_895f40d6});
        check("vec_r12_valid", {511'd0, r12_valid}, 512'd1);
        check("vec_r12", {448'd0, r12_data[511:448]}, {448'd0, 64'h9bf49a6a_0755f953});
        check("vec_r12_full", r12_data, ref_block('0, 1'b1, '0, '0, 12));

        // init then next: counter 1 with the same key.
        wait_idle();
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        wait_valid();
        check("next_ctr", {448'd0, block_ctr}, 512'd1);
        check("next_data", data_out, ref_block('0, 1'b1, '0, 64'd1, 20));

        // Randomized traffic, including simultaneous and mid-block requests.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            init   = ($urandom_range(0, 11) == 0);
            next   = ($urandom_range(0, 3) == 0);
            key    = rand_key();
            keylen = 1'(($urandom_range(0, 1)));
            iv     = {$urandom, $urandom};
        end
        @(negedge clk);
        init = 1'b0; next = 1'b0;

        // init+next together, then ignored requests while busy.
        wait_idle();
        key_a = rand_key(); key_b = rand_key(); keylen = 1'b0; iv = 64'h0123_4567_89ab_cdef;
        key = key_a; init = 1'b1; next = 1'b1;
        @(negedge clk);
        init = 1'b0; next = 1'b0; key = key_b;
        repeat (5) @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0; next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        wait_valid();
        check("both_ctr", {448'd0, block_ctr}, 512'd0);
        check("both_data", data_out, ref_block(key_a, 1'b0, 64'h0123_4567_89ab_cdef, 64'd0, 20));

        // Counter wrap from all-ones.
        wait_idle();
        @(posedge clk);
        #2 force dut.r_ctr = 64'hFFFF_FFFF_FFFF_FFFF;
        m_ctr = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #2 release dut.r_ctr;
        @(negedge clk);
        check("forced_ctr", {448'd0, block_ctr}, {448'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        wait_valid();
        check("wrap_ctr", {448'd0, block_ctr}, 512'd0);
        check("wrap_data", data_out, ref_block(key_a, 1'b0, 64'h0123_4567_89ab_cdef, 64'd0, 20));

        // Reset in the middle of a block.
        wait_idle();
        key_c = rand_key(); key = key_c; keylen = 1'b1; iv = 64'hfeed_face_cafe_beef;
        init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
        repeat (7) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_ready", {511'd0, ready}, 512'd1);
        check("midrst_valid", {511'd0, data_out_valid}, 512'd0);
        check("midrst_ctr", {448'd0, block_ctr}, 512'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        wait_valid();
        check("post_rst_data", data_out, ref_block(key_c, 1'b1, 64'hfeed_face_cafe_beef, 64'd0, 20));

        repeat (3) @(negedge clk);
        run_cmp = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
